// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle RV32I main control FSM
// Sequences FETCH/DECODE/EXEC/MEM/WB around IMEM/DMEM req/ack handshakes and drives the ALU control inputs.
module main_control_fsm #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic [2:0]       aluop,
  output logic [3:0]       instruccion,
  output logic [31:0]      ir,
  output logic             alusrc,
  output logic             reg_write,
  output logic             memtoreg,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q, bus_err_q;
  logic [15:0]      wait_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_zero, is_load, is_store, is_branch, is_jump;
  logic       dec_legal, dec_src;
  logic [2:0] dec_aluop;
  logic [3:0] dec_funct;
  logic       req_wait, timeout;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign rd_zero   = (ir_q[11:7] == 5'd0);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  // funct7[5] only selects an ALU variant for R ops and the I-type shifts (funct3 001/101)
  assign dec_funct = ((opcode == OP_R) || ((opcode == OP_I) && (funct3[1:0] == 2'b01)))
                     ? {ir_q[30], funct3} : {1'b0, funct3};

  always_comb begin
    dec_legal = 1'b1;
    dec_aluop = 3'b000;
    dec_src   = 1'b0;
    case (opcode)
      OP_R:      dec_aluop = 3'b000;
      OP_I:      begin dec_aluop = 3'b001; dec_src = 1'b1; end
      OP_LOAD:   begin dec_aluop = 3'b010; dec_src = 1'b1; end
      OP_STORE:  begin dec_aluop = 3'b011; dec_src = 1'b1; end
      OP_BRANCH: dec_aluop = 3'b100;
      OP_LUI:    begin dec_aluop = 3'b101; dec_src = 1'b1; end
      OP_AUIPC:  begin dec_aluop = 3'b110; dec_src = 1'b1; end
      OP_JAL:    dec_aluop = 3'b111;
      OP_JALR:   begin dec_aluop = 3'b111; dec_src = 1'b1; end
      default:   dec_legal = 1'b0;
    endcase
  end

  // An ack on the last allowed cycle takes precedence over the timeout
  assign req_wait = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
  assign timeout  = req_wait && (({1'b0, wait_q} + 17'd1) == 17'(MAX_WAIT));

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    aluop       = 3'b000;
    instruccion = 4'b0000;
    alusrc      = 1'b0;
    reg_write   = 1'b0;
    memtoreg    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)     state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          pc_write = is_store;
          state_d  = is_store ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = !rd_zero;
        memtoreg  = is_load;
        pc_write  = 1'b1;
        pc_sel    = is_jump;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      aluop       = dec_aluop;
      instruccion = dec_funct;
      alusrc      = dec_src;
    end
    // Outputs are forced quiet for the whole reset window, including an access in flight
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      aluop     = 3'b000;
      instruccion = 4'b0000;
      alusrc    = 1'b0;
      reg_write = 1'b0;
      memtoreg  = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_FETCH) && imem_ack) ir_q <= imem_rdata;
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
      if ((state_q == S_DECODE) && !dec_legal) illegal_q <= 1'b1;
      if (timeout) bus_err_q <= 1'b1;
      wait_q <= req_wait ? wait_q + 16'd1 : 16'd0;
    end
  end

  assign ir      = rst ? 32'd0 : ir_q;
  assign instret = rst ? '0 : instret_q;
  assign illegal = rst ? 1'b0 : illegal_q;
  assign bus_err = rst ? 1'b0 : bus_err_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - self-checking bench for main_control_fsm
// Vector table of known instructions, randomized instruction stream against a reference model, plus trap/reset sequences.
module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst, imem_ack, dmem_ack, branch_taken;
  logic [31:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, alusrc, reg_write, memtoreg, pc_write, pc_sel, illegal, bus_err;
  logic [2:0]  aluop;
  logic [3:0]  instruccion;
  logic [31:0] ir, instret;

  main_control_fsm #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken),
    .aluop(aluop), .instruccion(instruccion), .ir(ir),
    .alusrc(alusrc), .reg_write(reg_write), .memtoreg(memtoreg),
    .pc_write(pc_write), .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we;
    logic [2:0] aluop;
    logic [3:0] instr;
    logic       alusrc, reg_write, memtoreg, pc_write, pc_sel, illegal, bus_err;
  } outs_t;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3;

  typedef struct {
    logic [31:0] word;
    int          id;
    int          dd;
    bit          tk;
    int          kind;
    logic [2:0]  aluop;
    logic [3:0]  instr;
    bit          src;
    bit          rw;
    bit          psel;
    int          cyc;
  } vec_t;

  // Legal opcodes listed in ALUOP order; JALR shares ALUOP 111 with JAL
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  localparam logic [8:0] SRC_MASK = 9'b101101110;

  int errors = 0;
  int checks = 0;
  int exp_instret = 0;
  int cur_cyc, pcw_at;
  vec_t tbl [16];

  function automatic outs_t act_outs();
    outs_t a;
    a.imem_req = imem_req; a.dmem_req = dmem_req; a.dmem_we = dmem_we;
    a.aluop = aluop; a.instr = instruccion; a.alusrc = alusrc;
    a.reg_write = reg_write; a.memtoreg = memtoreg; a.pc_write = pc_write;
    a.pc_sel = pc_sel; a.illegal = illegal; a.bus_err = bus_err;
    return a;
  endfunction

  task automatic chk_outs(input string nm, input outs_t e);
    outs_t a;
    a = act_outs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic rand_idle();
    imem_ack     = 1'($urandom_range(0, 1));
    dmem_ack     = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    imem_rdata   = $urandom;
  endtask

  task automatic cycle_chk(input string nm, input outs_t e);
    @(negedge clk);
    chk_outs(nm, e);
    chk_val({nm, "_instret"}, instret, exp_instret);
    if (pc_write && pcw_at < 0) pcw_at = cur_cyc;
    cur_cyc++;
    @(posedge clk);
    #1;
    if (e.pc_write) exp_instret++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      chk_outs("reset", '0);
      chk_val("reset_instret", instret, 32'd0);
      chk_val("reset_ir", ir, 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_instret = 0;
  endtask

  function automatic outs_t base_of(input vec_t v);
    outs_t b;
    b = '0;
    b.aluop = v.aluop; b.instr = v.instr; b.alusrc = v.src;
    return b;
  endfunction

  function automatic vec_t model(input int idx, input logic [31:0] w, input int id, input int dd, input bit tk);
    vec_t v;
    logic [2:0] f3;
    bit shift, mem, wb;
    f3 = w[14:12];
    v.word = w; v.id = id; v.dd = dd; v.tk = tk;
    v.aluop = (idx > 7) ? 3'd7 : 3'(idx);
    v.kind = (idx == 2) ? K_LOAD : (idx == 3) ? K_STORE : (idx == 4) ? K_BR : K_ALU;
    v.src = SRC_MASK[idx];
    shift = (idx == 0) || (idx == 1 && (f3 == 3'd1 || f3 == 3'd5));
    v.instr = shift ? {w[30], f3} : {1'b0, f3};
    mem = (v.kind == K_LOAD) || (v.kind == K_STORE);
    wb = (v.kind == K_ALU) || (v.kind == K_LOAD);
    v.rw = wb && (w[11:7] != 5'd0);
    v.psel = (idx >= 7);
    v.cyc = (id + 1) + 2 + (mem ? dd + 1 : 0) + (wb ? 1 : 0);
    return v;
  endfunction

  task automatic run_instr(input string nm, input vec_t v);
    outs_t b, e;
    b = base_of(v);
    cur_cyc = 0;
    pcw_at = -1;
    for (int i = 0; i <= v.id; i++) begin
      rand_idle();
      imem_ack = (i == v.id);
      if (imem_ack) imem_rdata = v.word;
      e = '0; e.imem_req = 1'b1;
      cycle_chk({nm, "_fetch"}, e);
    end
    rand_idle();
    cycle_chk({nm, "_decode"}, b);
    chk_val({nm, "_ir"}, ir, v.word);
    rand_idle();
    e = b;
    if (v.kind == K_BR) begin
      branch_taken = v.tk;
      e.pc_write = 1'b1;
      e.pc_sel = v.tk;
    end
    cycle_chk({nm, "_exec"}, e);
    if (v.kind == K_LOAD || v.kind == K_STORE) begin
      for (int i = 0; i <= v.dd; i++) begin
        rand_idle();
        dmem_ack = (i == v.dd);
        e = b; e.dmem_req = 1'b1; e.dmem_we = (v.kind == K_STORE);
        e.pc_write = (v.kind == K_STORE) && (i == v.dd);
        cycle_chk({nm, "_mem"}, e);
      end
    end
    if (v.kind == K_ALU || v.kind == K_LOAD) begin
      rand_idle();
      e = b; e.reg_write = v.rw; e.memtoreg = (v.kind == K_LOAD);
      e.pc_write = 1'b1; e.pc_sel = v.psel;
      cycle_chk({nm, "_wb"}, e);
    end
    chk_val({nm, "_latency"}, 32'(pcw_at + 1), 32'(v.cyc));
  endtask

  task automatic run_random(input int n);
    int idx;
    logic [31:0] r;
    for (int k = 0; k < n; k++) begin
      idx = $urandom_range(0, 8);
      r = $urandom;
      run_instr("rnd", model(idx, {r[31:7], OPS[idx]}, $urandom_range(0, 3), $urandom_range(0, 3),
                             1'($urandom_range(0, 1))));
    end
  endtask

  task automatic trap_hold(input string nm, input outs_t e, input int n);
    for (int i = 0; i < n; i++) begin
      rand_idle();
      cycle_chk(nm, e);
    end
  endtask

  initial begin
    outs_t e;
    int saved;
    tbl[0]  = '{32'h40B50533, 0, 0, 1'b0, K_ALU,   3'b000, 4'b1000, 1'b0, 1'b1, 1'b0, 4};
    tbl[1]  = '{32'h0002A303, 0, 3, 1'b0, K_LOAD,  3'b010, 4'b0010, 1'b1, 1'b1, 1'b0, 8};
    tbl[2]  = '{32'h00B50463, 0, 0, 1'b1, K_BR,    3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 3};
    tbl[3]  = '{32'h00B50463, 0, 0, 1'b0, K_BR,    3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 3};
    tbl[4]  = '{32'h00500093, 0, 0, 1'b0, K_ALU,   3'b001, 4'b0000, 1'b1, 1'b1, 1'b0, 4};
    tbl[5]  = '{32'h4030D093, 0, 0, 1'b0, K_ALU,   3'b001, 4'b1101, 1'b1, 1'b1, 1'b0, 4};
    tbl[6]  = '{32'h4000F093, 0, 0, 1'b0, K_ALU,   3'b001, 4'b0111, 1'b1, 1'b1, 1'b0, 4};
    tbl[7]  = '{32'h0062A023, 0, 0, 1'b0, K_STORE, 3'b011, 4'b0010, 1'b1, 1'b0, 1'b0, 4};
    tbl[8]  = '{32'h123452B7, 0, 0, 1'b0, K_ALU,   3'b101, 4'b0101, 1'b1, 1'b1, 1'b0, 4};
    tbl[9]  = '{32'h00000197, 0, 0, 1'b0, K_ALU,   3'b110, 4'b0000, 1'b1, 1'b1, 1'b0, 4};
    tbl[10] = '{32'h008000EF, 0, 0, 1'b0, K_ALU,   3'b111, 4'b0000, 1'b0, 1'b1, 1'b1, 4};
    tbl[11] = '{32'h00008067, 0, 0, 1'b0, K_ALU,   3'b111, 4'b0000, 1'b1, 1'b0, 1'b1, 4};
    tbl[12] = '{32'h00000033, 0, 0, 1'b0, K_ALU,   3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 4};
    tbl[13] = '{32'h40B50533, 3, 0, 1'b0, K_ALU,   3'b000, 4'b1000, 1'b0, 1'b1, 1'b0, 7};
    tbl[14] = '{32'h0062A023, 0, 2, 1'b0, K_STORE, 3'b011, 4'b0010, 1'b1, 1'b0, 1'b0, 6};
    tbl[15] = '{32'h400010B3, 0, 0, 1'b0, K_ALU,   3'b000, 4'b1001, 1'b0, 1'b1, 1'b0, 4};

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; imem_rdata = 32'd0;
    do_reset(2);

    for (int i = 0; i < 16; i++) run_instr($sformatf("vec%0d", i), tbl[i]);
    chk_val("instret_after_table", instret, 32'd16);

    run_random(40);

    // Reset arriving while a store is waiting on DMEM aborts it and clears the counter
    saved = exp_instret;
    chk_val("instret_nonzero", 32'(saved > 0), 32'd1);
    rand_idle(); imem_ack = 1'b1; imem_rdata = tbl[7].word;
    e = '0; e.imem_req = 1'b1;
    cycle_chk("abort_fetch", e);
    rand_idle(); cycle_chk("abort_decode", base_of(tbl[7]));
    rand_idle(); cycle_chk("abort_exec", base_of(tbl[7]));
    rand_idle(); dmem_ack = 1'b0;
    e = base_of(tbl[7]); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    cycle_chk("abort_mem", e);
    do_reset(1);
    run_instr("after_abort", tbl[0]);

    // Unknown opcode traps and holds until reset
    rand_idle(); imem_ack = 1'b1; imem_rdata = 32'h0000007F;
    e = '0; e.imem_req = 1'b1;
    cycle_chk("ill_fetch", e);
    rand_idle(); cycle_chk("ill_decode", '0);
    e = '0; e.illegal = 1'b1;
    trap_hold("ill_trap", e, 4);
    do_reset(2);
    run_instr("after_ill", tbl[2]);

    // Fetch never acknowledged: four request cycles, then bus-error trap
    e = '0; e.imem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_idle(); imem_ack = 1'b0;
      cycle_chk("to_fetch", e);
    end
    e = '0; e.bus_err = 1'b1;
    trap_hold("to_trap", e, 3);
    do_reset(2);
    run_instr("ack_4th", tbl[13]);
    chk_val("no_bus_err", {31'd0, bus_err}, 32'd0);

    // Data access never acknowledged
    rand_idle(); imem_ack = 1'b1; imem_rdata = tbl[1].word;
    e = '0; e.imem_req = 1'b1;
    cycle_chk("dto_fetch", e);
    rand_idle(); cycle_chk("dto_decode", base_of(tbl[1]));
    rand_idle(); cycle_chk("dto_exec", base_of(tbl[1]));
    e = base_of(tbl[1]); e.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_idle(); dmem_ack = 1'b0;
      cycle_chk("dto_mem", e);
    end
    e = '0; e.bus_err = 1'b1;
    trap_hold("dto_trap", e, 3);
    do_reset(2);
    run_instr("after_dto", tbl[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
